blake2s_msg_sched: RTL

- Message scheduler and controller in front of the BLAKE2s-256 hash core (blake2s_hash256).
- Accepts a command (digest length) and an arbitrary-length byte stream, then segments it into 64-byte blocks.
- Zero-pads the final block and drives the core's block_first/block_last/ll/data_idx sequencing.
- Forwards the nn digest bytes to a downstream valid/last stream. Unkeyed hashing only.

---
 rtl/blake2s_pkg.sv | 22 ++
 rtl/blake2s_msg_sched_if.sv | 30 +++
 rtl/blake2_out_fmt.sv | 52 +++++
 rtl/blake2s_msg_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/blake2s_pkg.sv
// Shared constants, state encoding and digest-length clamp for the BLAKE2s
// message scheduler.
package blake2s_pkg;

  localparam int BB     = 64;
  localparam int NN_MAX = 32;
  localparam int LL_W   = 64;

  localparam logic [5:0] NN_DEFAULT = 6'd32;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    PAD,
    WAIT_H
  } state_e;

  function automatic logic [5:0] clamp_nn(input logic [5:0] nn);
    return (nn == 6'd0 || nn > 6'(NN_MAX)) ? NN_DEFAULT : nn;
  endfunction

endpackage

// File: rtl/blake2s_msg_sched_if.sv
// Byte-level bus between the message scheduler (master) and the BLAKE2s core.
interface blake2s_msg_sched_if;
  import blake2s_pkg::*;

  logic [5:0]      kk_o;
  logic [5:0]      nn_o;
  logic [LL_W-1:0] ll_o;
  logic            block_first_o;
  logic            block_last_o;
  logic            slow_output_o;
  logic            data_v_o;
  logic [5:0]      data_idx_o;
  logic [7:0]      data_o;
  logic            ready_v_i;
  logic            h_v_i;
  logic [7:0]      h_i;

  modport master (
    output kk_o, nn_o, ll_o, block_first_o, block_last_o, slow_output_o,
    output data_v_o, data_idx_o, data_o,
    input  ready_v_i, h_v_i, h_i
  );

  modport slave (
    input  kk_o, nn_o, ll_o, block_first_o, block_last_o, slow_output_o,
    input  data_v_o, data_idx_o, data_o,
    output ready_v_i, h_v_i, h_i
  );

endinterface

// File: rtl/blake2_out_fmt.sv
// Forwards the first nn digest beats from the core to the output stream and
// flags the final one.
module blake2_out_fmt
  import blake2s_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       en_i,
  input  logic [5:0] nn_i,
  input  logic       h_v_i,
  input  logic [7:0] h_i,
  output logic       m_v_o,
  output logic [7:0] m_data_o,
  output logic       m_last_o,
  output logic       done_o
);

  logic [5:0] cnt_q, cnt_d;
  logic       m_v_q, m_v_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_last_q, m_last_d;
  logic       beat;

  assign beat   = en_i & h_v_i;
  assign done_o = beat & (cnt_q == nn_i - 6'd1);

  always_comb begin
    cnt_d    = en_i ? (beat ? cnt_q + 6'd1 : cnt_q) : 6'd0;
    m_v_d    = beat;
    m_data_d = beat ? h_i : m_data_q;
    m_last_d = done_o;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q    <= '0;
      m_v_q    <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      m_v_q    <= m_v_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
    end
  end

  assign m_v_o    = m_v_q;
  assign m_data_o = m_data_q;
  assign m_last_o = m_last_q;

endmodule

// File: rtl/blake2s_msg_sched.sv
// BLAKE2s message scheduler: segments a byte stream into zero-padded 64-byte
// blocks for the core and forwards the digest bytes downstream.
module blake2s_msg_sched
  import blake2s_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       cmd_v_i,
  output logic       cmd_ready_o,
  input  logic [5:0] cmd_nn_i,
  input  logic       cmd_empty_i,
  input  logic       cmd_slow_i,
  input  logic       s_v_i,
  input  logic [7:0] s_data_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic       m_v_o,
  output logic [7:0] m_data_o,
  output logic       m_last_o,
  output logic       busy_o,
  blake2s_msg_sched_if.master core
);

  state_e          state_q, state_d;
  logic [5:0]      nn_q, nn_d;
  logic            slow_q, slow_d;
  logic [LL_W-1:0] ll_q, ll_d;
  logic [5:0]      idx_q, idx_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            clr_first_q, clr_first_d;
  logic            dv_q, dv_d;
  logic [5:0]      didx_q, didx_d;
  logic [7:0]      dat_q, dat_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            fmt_done;
  logic            s_acc;
  logic            idx_end;

  assign s_ready_o = (state_q == FEED) & core.ready_v_i;
  assign s_acc     = s_v_i & s_ready_o;
  assign idx_end   = (idx_q == 6'(BB - 1));

  always_comb begin
    state_d     = state_q;
    nn_d        = nn_q;
    slow_d      = slow_q;
    ll_d        = ll_q;
    idx_d       = idx_q;
    first_d     = first_q;
    last_d      = last_q;
    clr_first_d = clr_first_q;
    didx_d      = didx_q;
    dat_d       = dat_q;
    // A held byte leaves whenever the core is ready; new bytes are only
    // loaded in such cycles, so the holding register never overflows.
    dv_d        = core.ready_v_i ? 1'b0 : dv_q;

    case (state_q)
      IDLE: begin
        if (cmd_v_i && cmd_ready_q) begin
          nn_d        = clamp_nn(cmd_nn_i);
          slow_d      = cmd_slow_i;
          ll_d        = '0;
          idx_d       = '0;
          first_d     = 1'b1;
          last_d      = cmd_empty_i;
          clr_first_d = 1'b0;
          state_d     = cmd_empty_i ? PAD : FEED;
        end
      end
      FEED: begin
        if (s_acc) begin
          dat_d  = s_data_i;
          didx_d = idx_q;
          dv_d   = 1'b1;
          ll_d   = ll_q + LL_W'(1);
          idx_d  = idx_q + 6'd1;
          // first drops with block 1's byte 0 so block 0's idx 63 still sees it.
          if (clr_first_q) begin
            first_d     = 1'b0;
            clr_first_d = 1'b0;
          end
          if (s_last_i) begin
            last_d  = 1'b1;
            state_d = idx_end ? WAIT_H : PAD;
          end else if (idx_end) begin
            clr_first_d = 1'b1;
          end
        end
      end
      PAD: begin
        if (core.ready_v_i) begin
          dat_d  = 8'd0;
          didx_d = idx_q;
          dv_d   = 1'b1;
          idx_d  = idx_q + 6'd1;
          if (idx_end) state_d = WAIT_H;
        end
      end
      WAIT_H: begin
        if (fmt_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      nn_q        <= '0;
      slow_q      <= 1'b0;
      ll_q        <= '0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      clr_first_q <= 1'b0;
      dv_q        <= 1'b0;
      didx_q      <= '0;
      dat_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nn_q        <= nn_d;
      slow_q      <= slow_d;
      ll_q        <= ll_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      last_q      <= last_d;
      clr_first_q <= clr_first_d;
      dv_q        <= dv_d;
      didx_q      <= didx_d;
      dat_q       <= dat_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  blake2_out_fmt u_out_fmt (
    .clk      (clk),
    .nreset   (nreset),
    .en_i     (state_q == WAIT_H),
    .nn_i     (nn_q),
    .h_v_i    (core.h_v_i),
    .h_i      (core.h_i),
    .m_v_o    (m_v_o),
    .m_data_o (m_data_o),
    .m_last_o (m_last_o),
    .done_o   (fmt_done)
  );

  assign cmd_ready_o        = cmd_ready_q;
  assign busy_o             = busy_q;
  assign core.kk_o          = 6'd0;
  assign core.nn_o          = nn_q;
  assign core.ll_o          = ll_q;
  assign core.block_first_o = first_q;
  assign core.block_last_o  = last_q;
  assign core.slow_output_o = slow_q;
  assign core.data_v_o      = dv_q & core.ready_v_i;
  assign core.data_idx_o    = didx_q;
  assign core.data_o        = dat_q;

endmodule
